// File: rtl/fir_uart_bridge.sv
// Byte-serial bridge: assembles UART bytes into a FIR sample, then streams the FIR result back out MSB byte first.
// Optional inter-byte timeout in COLLECT is compiled in with `define FIR_BRIDGE_TIMEOUT_EN.
module fir_uart_bridge #(
   parameter int IN_BYTES       = 2,
   parameter int OUT_WIDTH      = 38,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_done,
   input  logic [7:0]            rx_data,
   input  logic [OUT_WIDTH-1:0]  fir_data_out,
   input  logic                  output_valid,
   input  logic                  txd_busy,
   output logic                  input_valid,
   output logic [8*IN_BYTES-1:0] fir_data_in,
   output logic                  txd_start,
   output logic [7:0]            tx_data,
   output logic                  overrun,
   output logic                  busy
);

   localparam int IN_W      = 8 * IN_BYTES;
   localparam int OUT_BYTES = (OUT_WIDTH + 7) / 8;
   localparam int EXT_W     = 8 * OUT_BYTES;
   localparam int CNT_W     = $clog2(IN_BYTES + 1);
   localparam int IDX_W     = $clog2(OUT_BYTES + 1);

   if (IN_BYTES < 1 || IN_BYTES > 4 || OUT_WIDTH < 8 || OUT_WIDTH > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("fir_uart_bridge: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE, COLLECT, START_FIR, WAIT_FIR, TX_START, TX_HOLD, TX_WAIT
   } state_t;

   state_t             state, state_next;
   logic               rx_d;
   logic [CNT_W-1:0]   byte_cnt;
   logic [IDX_W-1:0]   tx_idx;
   logic [OUT_WIDTH-1:0] out_reg;
   logic [EXT_W-1:0]   out_ext;
   logic               rx_rise;
   logic               collecting;
   logic               last_byte;
   logic               last_idx;
   logic               timed_out;

   assign rx_rise    = rx_done & ~rx_d;
   assign collecting = (state == IDLE) || (state == COLLECT);
   assign last_byte  = (byte_cnt == CNT_W'(IN_BYTES - 1));
   assign last_idx   = (tx_idx == IDX_W'(OUT_BYTES - 1));

`ifdef FIR_BRIDGE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] timer;

   // Counts idle cycles since the last accepted byte; restarts on every byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (state != COLLECT || rx_rise) begin
         timer <= '0;
      end else begin
         timer <= timer + TMR_W'(1);
      end
   end

   assign timed_out = (state == COLLECT) && !rx_rise && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: defaults first, so no path through this block leaves an output unassigned (no latch).
   always_comb begin
      state_next  = state;
      input_valid = 1'b0;
      txd_start   = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE, COLLECT: begin
            if (rx_rise) begin
               state_next = last_byte ? START_FIR : COLLECT;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         START_FIR: begin
            input_valid = 1'b1;
            state_next  = WAIT_FIR;
         end
         WAIT_FIR: begin
            if (output_valid) state_next = TX_START;
         end
         TX_START: begin
            if (!txd_busy) begin
               txd_start  = 1'b1;
               state_next = TX_HOLD;
            end
         end
         TX_HOLD: state_next = TX_WAIT;
         TX_WAIT: begin
            if (!txd_busy) state_next = last_idx ? IDLE : TX_START;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_d        <= 1'b0;
         byte_cnt    <= '0;
         tx_idx      <= '0;
         fir_data_in <= '0;
         out_reg     <= '0;
         overrun     <= 1'b0;
      end else begin
         rx_d <= rx_done;
         if (collecting && rx_rise) begin
            fir_data_in <= (fir_data_in << 8) | IN_W'(rx_data);
            byte_cnt    <= last_byte ? '0 : byte_cnt + CNT_W'(1);
         end else if (timed_out) begin
            byte_cnt <= '0;
         end
         // A byte arriving outside collection is lost; the flag stays set until reset.
         if (!collecting && rx_rise) overrun <= 1'b1;
         if (state == WAIT_FIR && output_valid) begin
            out_reg <= fir_data_out;
            tx_idx  <= '0;
         end
         if (state == TX_WAIT && !txd_busy) begin
            tx_idx <= last_idx ? '0 : tx_idx + IDX_W'(1);
         end
      end
   end

   // Top byte carries the sign when OUT_WIDTH is not byte aligned.
   always_comb begin
      out_ext                = {EXT_W{out_reg[OUT_WIDTH-1]}};
      out_ext[OUT_WIDTH-1:0] = out_reg;
      tx_data                = 8'h00;
      for (int i = 0; i < OUT_BYTES; i++) begin
         if (tx_idx == IDX_W'(i)) tx_data = out_ext[8*(OUT_BYTES-1-i) +: 8];
      end
   end

endmodule

// File: tb/tb_fir_uart_bridge.sv
// Directed bench for fir_uart_bridge with a transaction-level expectation model and per-cycle compare process.
module tb_fir_uart_bridge;

   localparam int IN_BYTES  = 2;
   localparam int OUT_WIDTH = 38;
   localparam int OUT_BYTES = 5;
`ifdef FIR_BRIDGE_TIMEOUT_EN
   localparam int TO_CYC = 20;
`else
   localparam int TO_CYC = 100000;
`endif

   logic                  clk;
   logic                  rst;
   logic                  rx_done;
   logic [7:0]            rx_data;
   logic [OUT_WIDTH-1:0]  fir_data_out;
   logic                  output_valid;
   logic                  txd_busy;
   logic                  input_valid;
   logic [8*IN_BYTES-1:0] fir_data_in;
   logic                  txd_start;
   logic [7:0]            tx_data;
   logic                  overrun;
   logic                  busy;

   fir_uart_bridge #(
      .IN_BYTES(IN_BYTES), .OUT_WIDTH(OUT_WIDTH), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
      .fir_data_out(fir_data_out), .output_valid(output_valid), .txd_busy(txd_busy),
      .input_valid(input_valid), .fir_data_in(fir_data_in), .txd_start(txd_start),
      .tx_data(tx_data), .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      total++;
      bad++;
      $display("FAIL %s: %s", name, why);
   endtask

   // Expectation model: samples and transmit bytes as transactions.
   logic [15:0] exp_sample_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [7:0]  tx_log[$];
   logic        exp_overrun = 1'b0;
   logic [63:0] part = '0;
   int          pcount = 0;
   int          iv_count = 0;
   int          ts_count = 0;
   int          busy_len = 3;

   function automatic void push_result(input logic [63:0] v);
      logic [63:0] mask;
      logic [63:0] ext;
      mask = (64'd1 << OUT_WIDTH) - 64'd1;
      ext  = v & mask;
      if (v[OUT_WIDTH-1]) ext = ext | ~mask;
      for (int k = 0; k < OUT_BYTES; k++) begin
         exp_tx_q.push_back(8'((ext >> (8 * (OUT_BYTES - 1 - k))) & 64'hFF));
      end
   endfunction

   function automatic void model_reset();
      exp_sample_q.delete();
      exp_tx_q.delete();
      exp_overrun = 1'b0;
      part        = '0;
      pcount      = 0;
   endfunction

   // Compare process: every cycle, away from the rising edge.
   logic       prev_iv = 1'b0;
   logic       holding = 1'b0;
   logic       seen_busy = 1'b0;
   logic [7:0] hold_val = '0;

   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         prev_iv   = 1'b0;
         holding   = 1'b0;
         seen_busy = 1'b0;
      end else begin
         if (input_valid) begin
            check("iv_one_cycle", prev_iv, 1'b0);
            if (exp_sample_q.size() == 0) fail("iv_unexpected", "input_valid with no complete sample");
            else check("sample", fir_data_in, exp_sample_q.pop_front());
            iv_count++;
         end
         prev_iv = input_valid;
         if (txd_start) begin
            check("start_not_busy", txd_busy, 1'b0);
            if (exp_tx_q.size() == 0) fail("tx_unexpected", $sformatf("txd_start with tx_data 0x%0h, none expected", tx_data));
            else check("tx_byte", tx_data, exp_tx_q.pop_front());
            tx_log.push_back(tx_data);
            ts_count++;
            hold_val  = tx_data;
            holding   = 1'b1;
            seen_busy = 1'b0;
         end else if (holding) begin
            if (txd_busy) begin
               check("tx_stable", tx_data, hold_val);
               seen_busy = 1'b1;
            end else if (seen_busy) begin
               holding = 1'b0;
            end
         end
         check("overrun", overrun, exp_overrun);
      end
   end

   // Transmitter model: busy rises the edge after a start and stays for busy_len cycles.
   always begin
      @(negedge clk);
      if (txd_start === 1'b1 && rst === 1'b0) begin
         @(posedge clk);
         #1 txd_busy = 1'b1;
         repeat (busy_len) @(posedge clk);
         #1 txd_busy = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit drop, output logic iv_after);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      if (drop) begin
         exp_overrun = 1'b1;
      end else begin
         part = (part << 8) | 64'(b);
         pcount++;
         if (pcount == IN_BYTES) begin
            exp_sample_q.push_back(16'(part));
            part   = '0;
            pcount = 0;
         end
      end
      @(negedge clk);
      iv_after = input_valid;
      rx_done  = 1'b0;
   endtask

   task automatic pulse_result(input logic [OUT_WIDTH-1:0] v);
      @(negedge clk);
      fir_data_out = v;
      output_valid = 1'b1;
      push_result(64'(v));
      @(negedge clk);
      output_valid = 1'b0;
   endtask

   task automatic wait_iv(input int old);
      int n = 0;
      while (iv_count <= old && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (iv_count <= old) fail("iv_wait", "input_valid never seen within 200 cycles");
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (busy !== 1'b0) fail("idle_wait", $sformatf("busy still %b after %0d cycles", busy, budget));
   endtask

   task automatic wait_starts(input int target);
      int n = 0;
      while (ts_count < target && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (ts_count < target) fail("start_wait", $sformatf("only %0d starts, want %0d", ts_count, target));
   endtask

   localparam logic [7:0] A_BYTES [5] = '{8'hE0, 8'h12, 8'h34, 8'h56, 8'h78};

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic iv;
      int   base, iv_old, ts_old;

      rst = 1'b0; rx_done = 1'b0; rx_data = '0; fir_data_out = '0;
      output_valid = 1'b0; txd_busy = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_input_valid", input_valid, 1'b0);
      check("rst_txd_start", txd_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_overrun", overrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_fir_data_in", fir_data_in, 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic sample and five-byte result.
      busy_len = 3;
      iv_old = iv_count;
      send_byte(8'h12, 1'b0, iv);
      check("a_iv_after_first", iv, 1'b0);
      check("a_busy_collect", busy, 1'b1);
      send_byte(8'h34, 1'b0, iv);
      check("a_iv_after_second", iv, 1'b1);
      wait_iv(iv_old);
      check("a_iv_count", iv_count - iv_old, 1);
      repeat (3) @(negedge clk);
      check("a_sample_literal", fir_data_in, 16'h1234);
      base   = tx_log.size();
      ts_old = ts_count;
      pulse_result(38'h20_1234_5678);
      wait_idle(500);
      check("a_start_count", ts_count - ts_old, 5);
      if (tx_log.size() >= base + 5) begin
         for (int i = 0; i < 5; i++) check($sformatf("a_lit_byte%0d", i), tx_log[base + i], A_BYTES[i]);
      end else begin
         fail("a_lit_bytes", $sformatf("only %0d bytes logged", tx_log.size() - base));
      end

      // Long transmitter busy periods.
      busy_len = 50;
      iv_old = iv_count;
      send_byte(8'hAB, 1'b0, iv);
      send_byte(8'hCD, 1'b0, iv);
      wait_iv(iv_old);
      base   = tx_log.size();
      ts_old = ts_count;
      pulse_result(38'h1F_FFFF_FFFF);
      wait_idle(1000);
      check("b_start_count", ts_count - ts_old, 5);
      if (tx_log.size() > base) check("b_top_byte", tx_log[base], 8'h1F);

      // Byte dropped while waiting for the FIR.
      busy_len = 2;
      iv_old = iv_count;
      send_byte(8'h80, 1'b0, iv);
      send_byte(8'h01, 1'b0, iv);
      wait_iv(iv_old);
      repeat (2) @(negedge clk);
      check("c_overrun_before", overrun, 1'b0);
      send_byte(8'h55, 1'b1, iv);
      check("c_overrun_set", overrun, 1'b1);
      check("c_sample_kept", fir_data_in, 16'h8001);
      ts_old = ts_count;
      pulse_result(38'h3F_FFFF_FFFE);
      wait_idle(300);
      check("c_start_count", ts_count - ts_old, 5);
      check("c_overrun_sticky", overrun, 1'b1);

      // Reset during the third transmitted byte.
      busy_len = 10;
      iv_old = iv_count;
      send_byte(8'h11, 1'b0, iv);
      send_byte(8'h22, 1'b0, iv);
      wait_iv(iv_old);
      ts_old = ts_count;
      pulse_result(38'h01_0203_0405);
      wait_starts(ts_old + 3);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("d_rst_input_valid", input_valid, 1'b0);
      check("d_rst_txd_start", txd_start, 1'b0);
      check("d_rst_tx_data", tx_data, 8'h00);
      check("d_rst_overrun", overrun, 1'b0);
      check("d_rst_busy", busy, 1'b0);
      check("d_rst_fir_data_in", fir_data_in, 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ts_old = ts_count;
      repeat (80) @(negedge clk);
      check("d_no_start_after_rst", ts_count - ts_old, 0);

      // Fresh sample after reset; dropped byte coincident with output_valid.
      busy_len = 2;
      iv_old = iv_count;
      send_byte(8'h00, 1'b0, iv);
      send_byte(8'h07, 1'b0, iv);
      check("e_iv_after_second", iv, 1'b1);
      wait_iv(iv_old);
      repeat (2) @(negedge clk);
      ts_old = ts_count;
      @(negedge clk);
      rx_data = 8'h99; rx_done = 1'b1;
      fir_data_out = 38'h00_0000_0007; output_valid = 1'b1;
      push_result(64'h7);
      @(posedge clk);
      #1 exp_overrun = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; output_valid = 1'b0;
      wait_idle(300);
      check("e_start_count", ts_count - ts_old, 5);
      check("e_overrun", overrun, 1'b1);
      check("e_sample_kept", fir_data_in, 16'h0007);

`ifdef FIR_BRIDGE_TIMEOUT_EN
      iv_old = iv_count;
      send_byte(8'hDE, 1'b0, iv);
      repeat (10) @(negedge clk);
      check("f_still_collecting", busy, 1'b1);
      wait_idle(40);
      part = '0;
      pcount = 0;
      check("f_no_iv_on_timeout", iv_count - iv_old, 0);
      check("f_data_unchanged", fir_data_in, 16'h07DE);
      send_byte(8'hBE, 1'b0, iv);
      check("f_iv_after_first", iv, 1'b0);
      send_byte(8'hEF, 1'b0, iv);
      check("f_iv_after_second", iv, 1'b1);
      wait_iv(iv_old);
      check("f_fresh_sample", fir_data_in, 16'hBEEF);
`else
      iv_old = iv_count;
      send_byte(8'hDE, 1'b0, iv);
      repeat (300) @(negedge clk);
      check("f_still_collecting", busy, 1'b1);
      send_byte(8'hAD, 1'b0, iv);
      check("f_iv_after_second", iv, 1'b1);
      wait_iv(iv_old);
      check("f_late_sample", fir_data_in, 16'hDEAD);
`endif
      ts_old = ts_count;
      pulse_result(38'h15_5555_AAAA);
      wait_idle(300);
      check("f_start_count", ts_count - ts_old, 5);
      check("f_queue_drained", exp_tx_q.size(), 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
